// File: rtl/sync_counter_n_if.sv
// Control/data bundle for sync_counter_n. Defining SYNC_COUNTER_N_CMP_EN adds
// the cmp/match compare signals to the bundle.
interface sync_counter_n_if #(
  parameter int WIDTH = 4
);
  logic             sr;
  logic             pe;
  logic [WIDTH-1:0] d;
  logic             cet;
  logic             cep;
  logic             up;
  logic [WIDTH-1:0] q;
  logic             tc;
`ifdef SYNC_COUNTER_N_CMP_EN
  logic [WIDTH-1:0] cmp;
  logic             match;
`endif

  modport master (
    output sr, pe, d, cet, cep, up,
`ifdef SYNC_COUNTER_N_CMP_EN
    output cmp,
    input  match,
`endif
    input  q, tc
  );

  modport slave (
    input  sr, pe, d, cet, cep, up,
`ifdef SYNC_COUNTER_N_CMP_EN
    input  cmp,
    output match,
`endif
    output q, tc
  );
endinterface

// File: rtl/sync_counter_n.sv
// Cascadable modulus-(MAXVAL+1) up/down counter with sync reset and parallel load.
// Optional registered compare output enabled by defining SYNC_COUNTER_N_CMP_EN.
module sync_counter_n #(
  parameter int WIDTH  = 4,
  parameter int MAXVAL = 2**WIDTH - 1
) (
  input  logic            cp,
  input  logic            mr,
  sync_counter_n_if.slave bus
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAXVAL);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;

  // Out-of-range loaded values wrap to 0 going up and step down normally.
  always_comb begin
    q_nxt = q_r;
    if (!bus.sr) begin
      q_nxt = '0;
    end else if (!bus.pe) begin
      q_nxt = bus.d;
    end else if (bus.cet && bus.cep) begin
      if (bus.up) begin
        q_nxt = (q_r >= MAXV) ? '0 : q_r + ONE;
      end else begin
        q_nxt = (q_r == '0) ? MAXV : q_r - ONE;
      end
    end
  end

  always_ff @(posedge cp or negedge mr) begin
    if (!mr) begin
      q_r <= '0;
    end else begin
      q_r <= q_nxt;
    end
  end

  assign bus.q = q_r;

  always_comb begin
    bus.tc = bus.cet & (bus.up ? (q_r == MAXV) : (q_r == '0));
  end

`ifdef SYNC_COUNTER_N_CMP_EN
  logic match_r;

  // Compares the value being written, so loads and sync resets also hit.
  always_ff @(posedge cp or negedge mr) begin
    if (!mr) begin
      match_r <= 1'b0;
    end else begin
      match_r <= (q_nxt == bus.cmp);
    end
  end

  assign bus.match = match_r;
`endif

endmodule

// File: tb/tb_sync_counter_n.sv
// Randomized self-checking bench for sync_counter_n against an arithmetic model,
// plus directed sequences and a two-stage cascade.
module tb_sync_counter_n;
  localparam int W = 4;
  localparam int M = 9;

  logic cp = 1'b0;
  logic mr;
  int   errors = 0;
  int   checks = 0;
  int   mq;

  always #5 cp = ~cp;

  sync_counter_n_if #(.WIDTH(W)) b0 ();
  sync_counter_n_if #(.WIDTH(4)) clo ();
  sync_counter_n_if #(.WIDTH(4)) chi ();

  assign chi.sr  = clo.sr;
  assign chi.pe  = clo.pe;
  assign chi.d   = '0;
  assign chi.cep = clo.cep;
  assign chi.up  = clo.up;
  assign chi.cet = clo.tc;
`ifdef SYNC_COUNTER_N_CMP_EN
  assign clo.cmp = '0;
  assign chi.cmp = '0;
`endif

  sync_counter_n #(.WIDTH(W), .MAXVAL(M)) dut (.cp(cp), .mr(mr), .bus(b0));
  sync_counter_n #(.WIDTH(4)) u_lo (.cp(cp), .mr(mr), .bus(clo));
  sync_counter_n #(.WIDTH(4)) u_hi (.cp(cp), .mr(mr), .bus(chi));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_next(int q, bit sr, bit pe, bit cet, bit cep, bit up,
                                    int d, int m);
    if (!sr) return 0;
    if (!pe) return d;
    if (!(cet && cep)) return q;
    if (up) return (q >= m) ? 0 : q + 1;
    return (q == 0) ? m : q - 1;
  endfunction

  function automatic int model_tc();
    return int'(b0.cet && (b0.up ? (mq == M) : (mq == 0)));
  endfunction

  task automatic tick(input string tag);
    int e;
    e = model_next(mq, b0.sr, b0.pe, b0.cet, b0.cep, b0.up, int'(b0.d), M);
    @(posedge cp);
    #1;
    mq = e;
    check({tag, ".q"}, 32'(b0.q), 32'(mq));
    check({tag, ".tc"}, 32'(b0.tc), 32'(model_tc()));
`ifdef SYNC_COUNTER_N_CMP_EN
    check({tag, ".match"}, 32'(b0.match), 32'(mq == int'(b0.cmp)));
`endif
  endtask

  task automatic mr_pulse(input string tag);
    #3 mr = 1'b0;
    #1;
    mq = 0;
    check({tag, ".q"}, 32'(b0.q), 32'd0);
`ifdef SYNC_COUNTER_N_CMP_EN
    check({tag, ".match"}, 32'(b0.match), 32'd0);
`endif
    mr = 1'b1;
  endtask

  initial begin
    mr = 1'b0;
    mq = 0;
    b0.sr = 1'b1; b0.pe = 1'b1; b0.d = '0; b0.cet = 1'b0; b0.cep = 1'b0; b0.up = 1'b1;
`ifdef SYNC_COUNTER_N_CMP_EN
    b0.cmp = 4'd3;
`endif
    clo.sr = 1'b1; clo.pe = 1'b1; clo.d = '0; clo.cet = 1'b1; clo.cep = 1'b0; clo.up = 1'b1;

    // Reset state and tc behaviour while mr is held low
    #12;
    check("rst.q", 32'(b0.q), 32'd0);
    check("rst.tc_cet0", 32'(b0.tc), 32'd0);
    b0.cet = 1'b1; b0.up = 1'b0;
    #1 check("rst.tc_down", 32'(b0.tc), 32'd1);
    b0.up = 1'b1;
    #1 check("rst.tc_up", 32'(b0.tc), 32'd0);
`ifdef SYNC_COUNTER_N_CMP_EN
    check("rst.match", 32'(b0.match), 32'd0);
`endif
    check("rst.casc", 32'({chi.q, clo.q}), 32'd0);
    mr = 1'b1;

    // Count up 1..9,0
    b0.cep = 1'b1;
    for (int unsigned i = 0; i < 20; i++) tick("up");

    // Load 13 and count down through the out-of-range values
    b0.up = 1'b0; b0.pe = 1'b0; b0.d = 4'd13;
    tick("load13");
    b0.pe = 1'b1;
    for (int unsigned i = 0; i < 16; i++) tick("down");

    // sr beats pe, then load, then hold with tc following cet
    b0.up = 1'b1; b0.pe = 1'b0; b0.d = 4'd5;
    tick("load5");
    b0.sr = 1'b0; b0.d = 4'd7;
    tick("sr_pe");
    b0.sr = 1'b1;
    tick("pe7");
    b0.d = 4'd9;
    tick("pe9");
    b0.pe = 1'b1; b0.cep = 1'b0;
    tick("hold");
    b0.cet = 1'b0;
    #1 check("hold.tc_cet0", 32'(b0.tc), 32'd0);
    b0.cet = 1'b1;
    #1 check("hold.tc_cet1", 32'(b0.tc), 32'd1);
    tick("hold2");

    // Async reset mid-cycle aborts an enabled step
    b0.pe = 1'b0; b0.d = 4'd6;
    tick("load6");
    b0.pe = 1'b1; b0.cep = 1'b1;
    mr_pulse("mr");
    tick("after_mr");

    // Randomized traffic
    for (int unsigned i = 0; i < 400; i++) begin
      b0.sr  = ($urandom_range(0, 7) != 0);
      b0.pe  = ($urandom_range(0, 5) != 0);
      b0.d   = 4'($urandom_range(0, 15));
      b0.cet = ($urandom_range(0, 3) != 0);
      b0.cep = ($urandom_range(0, 3) != 0);
      b0.up  = 1'($urandom);
`ifdef SYNC_COUNTER_N_CMP_EN
      b0.cmp = 4'($urandom_range(0, 15));
`endif
      #1 check("rnd.tc_comb", 32'(b0.tc), 32'(model_tc()));
      tick("rnd");
      if ($urandom_range(0, 31) == 0) mr_pulse("rnd.mr");
    end

    // Two default stages cascaded: 256 edges wrap 0..255 back to 0
    check("casc.start", 32'({chi.q, clo.q}), 32'd0);
    clo.cep = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      @(posedge cp);
      #1;
      check("casc.q", 32'({chi.q, clo.q}), 32'(i % 256));
      check("casc.tc", 32'(chi.tc), 32'((i % 256) == 255));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
